// File: rtl/jt51_slot_port.sv
// Per-slot recirculating word ring with a host random-access port.
// The pipeline sees the head slot on dout; the host reaches a slot by waiting for it to pass.
module jt51_slot_port #(
    parameter int width  = 5,
    parameter int stages = 32,
    localparam int AW    = $clog2(stages)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [AW-1:0]    slot,
    output logic [width-1:0] dout,
    input  logic             upd_en,
    input  logic [width-1:0] upd_data,
    input  logic             req,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             ack,
    output logic             err,
    output logic [width-1:0] rdata
);

    // Host handshake: req/we/addr/wdata are sampled only in a cycle where busy=0.
    // busy stays high until and including the single-cycle ack; req while busy is dropped.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [AW-1:0] LAST  = AW'(stages - 1);
    localparam logic [AW:0]   LIMIT = (AW + 1)'(stages);

    state_t             state;
    state_t             state_nx;
    logic [width-1:0]   ring [stages];
    logic               we_l;
    logic [AW-1:0]      addr_l;
    logic [width-1:0]   wdata_l;
    logic               err_l;
    logic               out_of_range;
    logic               hit;
    logic               host_wr_hit;
    logic               host_rd_hit;
    logic [width-1:0]   tail;

    assign dout         = ring[0];
    assign out_of_range = {1'b0, addr} >= LIMIT;
    assign hit          = (state == S_WAIT) && (slot == addr_l);
    assign host_wr_hit  = hit && we_l;
    assign host_rd_hit  = hit && !we_l;
    // A host write wins over the pipeline update for the same slot.
    assign tail         = host_wr_hit ? wdata_l : (upd_en ? upd_data : dout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else begin
            slot <= (slot == LAST) ? '0 : slot + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < stages; i++) ring[i] <= '0;
        end else begin
            for (int i = 0; i < stages - 1; i++) ring[i] <= ring[i + 1];
            ring[stages - 1] <= tail;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            err_l   <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                we_l    <= we;
                addr_l  <= addr;
                wdata_l <= wdata;
                err_l   <= out_of_range;
            end
            if (host_rd_hit) rdata <= dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = out_of_range ? S_DONE : S_WAIT;
            S_WAIT:  if (hit) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        ack  = 1'b0;
        err  = 1'b0;
        case (state)
            S_WAIT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                ack  = 1'b1;
                err  = err_l;
            end
            default: ;
        endcase
    end

endmodule
